// File: rtl/data_mem_subsystem_if.sv
// CPU-side load/store bus of the data memory subsystem.
// The cpu drives requests and stalls while BUSYWAIT is high.
interface data_mem_subsystem_if;
    logic       READ;
    logic       WRITE;
    logic [7:0] ADDRESS;
    logic [7:0] WRITEDATA;
    logic [7:0] READDATA;
    logic       BUSYWAIT;

    modport master (output READ, output WRITE, output ADDRESS, output WRITEDATA,
                    input READDATA, input BUSYWAIT);
    modport slave  (input READ, input WRITE, input ADDRESS, input WRITEDATA,
                    output READDATA, output BUSYWAIT);
endinterface

// File: rtl/data_mem_subsystem.sv
// Direct-mapped write-back/write-allocate data cache in front of a slow
// 64 x 32-bit block memory, presenting a byte-wide stall interface to the cpu.
module data_mem_subsystem #(
    parameter int MEM_LATENCY = 5,
    parameter int NUM_BLOCKS  = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    data_mem_subsystem_if.slave  cpu
);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = 6 - IDX_W;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        MEM_READ     = 2'd1,
        MEM_WRITE    = 2'd2,
        CACHE_UPDATE = 2'd3
    } state_t;

    state_t            state_r, state_s;

    logic [31:0]       data_r  [NUM_BLOCKS];
    logic [TAG_W-1:0]  tag_r   [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_r;
    logic [NUM_BLOCKS-1:0] dirty_r;
    logic [31:0]       mem_r   [64];

    logic [5:0]        miss_addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       fetch_r;

    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic [1:0]        off_s;
    logic [IDX_W-1:0]  miss_idx_s;
    logic [IDX_W-1:0]  line_idx_s;
    logic              req_s;
    logic              hit_s;
    logic              cnt_done_s;
    logic              mem_read_s;
    logic              mem_write_s;
    logic              mem_busy_s;
    logic [5:0]        mem_addr_s;

    assign idx_s      = cpu.ADDRESS[IDX_W+1:2];
    assign tag_s      = cpu.ADDRESS[7:IDX_W+2];
    assign off_s      = cpu.ADDRESS[1:0];
    assign miss_idx_s = miss_addr_r[IDX_W-1:0];
    assign req_s      = cpu.READ | cpu.WRITE;
    assign hit_s      = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    assign cnt_done_s = (cnt_r == CNT_LAST);
    assign mem_busy_s = mem_read_s | mem_write_s;

    assign cpu.READDATA = data_r[idx_s][{off_s, 3'b000} +: 8];
    assign cpu.BUSYWAIT = req_s && !((state_r == IDLE) && hit_s);

    // Line being evicted/filled: the live address while idle, the latched miss address afterwards.
    always_comb begin
        line_idx_s = miss_idx_s;
        if (state_r == IDLE) begin
            line_idx_s = idx_s;
        end else begin
            line_idx_s = miss_idx_s;
        end
    end

    // Next-state and memory request logic; requests start in the miss cycle so memory counts from there.
    always_comb begin
        state_s     = state_r;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        mem_addr_s  = miss_addr_r;
        case (state_r)
            IDLE: begin
                if (req_s && !hit_s) begin
                    if (valid_r[idx_s] && dirty_r[idx_s]) begin
                        state_s     = MEM_WRITE;
                        mem_write_s = 1'b1;
                        mem_addr_s  = {tag_r[idx_s], idx_s};
                    end else begin
                        state_s    = MEM_READ;
                        mem_read_s = 1'b1;
                        mem_addr_s = cpu.ADDRESS[7:2];
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MEM_WRITE: begin
                mem_write_s = 1'b1;
                mem_addr_s  = {tag_r[miss_idx_s], miss_idx_s};
                if (cnt_done_s) begin
                    state_s = MEM_READ;
                end else begin
                    state_s = MEM_WRITE;
                end
            end
            MEM_READ: begin
                mem_read_s = 1'b1;
                mem_addr_s = miss_addr_r;
                if (cnt_done_s) begin
                    state_s = CACHE_UPDATE;
                end else begin
                    state_s = MEM_READ;
                end
            end
            CACHE_UPDATE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Backing memory: counts edges while requested, transfers on the last one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_r   <= '0;
            fetch_r <= 32'h0000_0000;
            for (int i = 0; i < 64; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (mem_busy_s) begin
            if (cnt_done_s) begin
                cnt_r <= '0;
                if (mem_write_s) begin
                    mem_r[mem_addr_s] <= data_r[line_idx_s];
                end else begin
                    fetch_r <= mem_r[mem_addr_s];
                end
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= '0;
        end
    end

    // Cache arrays and FSM state; a write miss becomes an ordinary write hit once the fill lands.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= IDLE;
            valid_r     <= '0;
            dirty_r     <= '0;
            miss_addr_r <= 6'd0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                data_r[i] <= 32'h0000_0000;
                tag_r[i]  <= '0;
            end
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && req_s && !hit_s) begin
                miss_addr_r <= cpu.ADDRESS[7:2];
            end
            if (state_r == CACHE_UPDATE) begin
                data_r[miss_idx_s]  <= fetch_r;
                tag_r[miss_idx_s]   <= miss_addr_r[5:IDX_W];
                valid_r[miss_idx_s] <= 1'b1;
                dirty_r[miss_idx_s] <= 1'b0;
            end else if ((state_r == IDLE) && hit_s && cpu.WRITE) begin
                data_r[idx_s][{off_s, 3'b000} +: 8] <= cpu.WRITEDATA;
                dirty_r[idx_s] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_subsystem.sv
// Scoreboarded directed test of the data cache + block memory subsystem:
// the driver queues expected stall/data per access, a monitor checks on completion.
module tb_data_mem_subsystem;
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    data_mem_subsystem_if bus();

    data_mem_subsystem #(.MEM_LATENCY(5), .NUM_BLOCKS(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .cpu   (bus)
    );

    typedef struct {
        logic       is_read;
        logic [7:0] data;
        int         stall;
        logic [7:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles and checks each access when BUSYWAIT releases it.
    always @(negedge CLK) begin
        if (RESET) begin
            stall_cnt = 0;
        end else if (bus.READ || bus.WRITE) begin
            if (bus.BUSYWAIT) begin
                stall_cnt++;
            end else begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_completion: addr %h with nothing queued", bus.ADDRESS);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("stall@%h", mon_e.addr), stall_cnt, mon_e.stall);
                    if (mon_e.is_read) begin
                        check($sformatf("readdata@%h", mon_e.addr), {24'd0, bus.READDATA}, {24'd0, mon_e.data});
                    end
                end
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    // Issue one access at posedge+1; hold it until BUSYWAIT is sampled low, then drop it after the edge.
    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_d, input int exp_stall);
        exp_t e;
        int n;
        e.is_read = rd && !wr;
        e.data    = exp_d;
        e.stall   = exp_stall;
        e.addr    = addr;
        exp_q.push_back(e);
        bus.READ = rd;
        bus.WRITE = wr;
        bus.ADDRESS = addr;
        bus.WRITEDATA = wd;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.BUSYWAIT && n < 40);
        if (bus.BUSYWAIT) begin
            total++;
            bad++;
            $display("FAIL timeout@%h: BUSYWAIT still high after %0d cycles", addr, n);
            void'(exp_q.pop_back());
        end
        @(posedge CLK);
        #1;
        bus.READ = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.READ = 1'b0;
        bus.WRITE = 1'b0;
        bus.ADDRESS = 8'h00;
        bus.WRITEDATA = 8'h00;
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("reset_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        check("reset_readdata", {24'd0, bus.READDATA}, 32'd0);
        @(posedge CLK);
        #1;

        // Cold misses, write allocate, then hits
        access(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 6);
        access(1'b0, 1'b1, 8'h05, 8'h5A, 8'h00, 6);
        access(1'b1, 1'b0, 8'h05, 8'h00, 8'h5A, 0);
        check("dirty1_after_write", {31'd0, dut.dirty_r[1]}, 32'd1);

        // Dirty eviction of line 1, then reload of the written-back byte
        access(1'b1, 1'b0, 8'h25, 8'h00, 8'h00, 11);
        check("mem_word1_writeback", dut.mem_r[1], 32'h0000_5A00);
        check("dirty1_after_fill", {31'd0, dut.dirty_r[1]}, 32'd0);
        access(1'b1, 1'b0, 8'h05, 8'h00, 8'h5A, 6);

        // Byte-lane hits within one line
        access(1'b0, 1'b1, 8'h06, 8'hAB, 8'h00, 0);
        access(1'b1, 1'b0, 8'h04, 8'h00, 8'h00, 0);
        access(1'b1, 1'b0, 8'h07, 8'h00, 8'h00, 0);
        access(1'b1, 1'b0, 8'h06, 8'h00, 8'hAB, 0);

        // READ and WRITE together act as a write
        access(1'b1, 1'b1, 8'h04, 8'h77, 8'h00, 0);
        access(1'b1, 1'b0, 8'h04, 8'h00, 8'h77, 0);

        // Clean eviction: no write-back phase
        access(1'b1, 1'b0, 8'h08, 8'h00, 8'h00, 6);
        access(1'b1, 1'b0, 8'h28, 8'h00, 8'h00, 6);

        // Dirty byte 3 round trip through memory
        access(1'b0, 1'b1, 8'h2B, 8'hC3, 8'h00, 0);
        access(1'b1, 1'b0, 8'h0B, 8'h00, 8'h00, 11);
        check("mem_word10_writeback", dut.mem_r[10], 32'hC300_0000);
        access(1'b1, 1'b0, 8'h2B, 8'h00, 8'hC3, 6);

        // Request withdrawn mid-miss: fill still completes for the original address
        bus.READ = 1'b1;
        bus.ADDRESS = 8'h30;
        repeat (2) @(posedge CLK);
        #1;
        bus.READ = 1'b0;
        bus.ADDRESS = 8'h00;
        repeat (10) @(posedge CLK);
        #1;
        access(1'b1, 1'b0, 8'h30, 8'h00, 8'h00, 0);
        access(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 0);

        // Reset during MEM_READ: lines and memory image are discarded
        bus.READ = 1'b1;
        bus.ADDRESS = 8'h14;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        bus.READ = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("idle_after_reset_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        @(posedge CLK);
        #1;
        access(1'b1, 1'b0, 8'h14, 8'h00, 8'h00, 6);
        access(1'b1, 1'b0, 8'h05, 8'h00, 8'h00, 6);

        repeat (3) @(posedge CLK);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
